strassen_result_streamer: RTL and testbench

Drains the product matrix from `strassen_matrix_mult` once its `done` pulse fires. It snapshots the full 16×16 signed result into a local buffer and streams it out one element per handshake in row-major order, over a valid/ready interface. This frees the multiplier for its next `start` and gives downstream logic (checkers, host DMA, UART bridge) a narrow, back-pressurable view of `C`.

---
 rtl/strassen_stream_pkg.sv | 16 +
 rtl/strassen_rc_counter.sv | 56 +++++
 rtl/strassen_result_streamer.sv | 117 +++++++++++
 tb/tb_strassen_result_streamer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strassen_stream_pkg.sv
// Shared sizes, element/matrix types and stream FSM states for the result streamer.
package strassen_stream_pkg;

    localparam int N_DEFAULT  = 16;
    localparam int DW_DEFAULT = 16;

    typedef logic signed [DW_DEFAULT-1:0] elem_t;
    typedef elem_t matrix_t [0:N_DEFAULT-1][0:N_DEFAULT-1];

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CKSUM
    } stream_state_e;

endpackage

// File: rtl/strassen_rc_counter.sv
// Row-major row/col walker: clear to (0,0), advance on enable, wrap at (N-1,N-1).
module strassen_rc_counter
    import strassen_stream_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [$clog2(N)-1:0] row,
    output logic [$clog2(N)-1:0] col,
    output logic                 at_end
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;

    always_comb begin
        // NOTE: hold values are assigned first so every path drives the
        // next-state signals and no latch is inferred.
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row    = row_q;
    assign col    = col_q;
    assign at_end = (row_q == LAST) && (col_q == LAST);

endmodule

// File: rtl/strassen_result_streamer.sv
// Snapshots the multiplier's result matrix and streams it row-major over valid/ready.
// Optional trailing wrap-around checksum beat: define STRASSEN_STREAM_CKSUM_EN.
module strassen_result_streamer
    import strassen_stream_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done_in,
    input  logic signed [DW-1:0] c_in [0:N-1][0:N-1],
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 overrun
);

    localparam int IW = $clog2(N);

`ifdef STRASSEN_STREAM_CKSUM_EN
    localparam stream_state_e AFTER_LAST = CKSUM;
`else
    localparam stream_state_e AFTER_LAST = IDLE;
`endif

    stream_state_e        state_q;
    logic                 overrun_q;
    logic signed [DW-1:0] data_buf_q [0:N-1][0:N-1];
    logic [IW-1:0]        row, col;
    logic                 at_end;
    logic                 capture, handshake, stream_hs;

    assign capture   = (state_q == IDLE) && done_in;
    assign handshake = out_valid && out_ready;
    assign stream_hs = (state_q == STREAM) && handshake;

    // The counter parks on (N-1,N-1) after the final element so the
    // checksum beat reports those indices without extra muxing.
    strassen_rc_counter #(.N(N)) u_rc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (capture),
        .en     (stream_hs && !at_end),
        .row    (row),
        .col    (col),
        .at_end (at_end)
    );

    // NOTE: the snapshot buffer is deliberately not reset; its contents are
    // only read after a capture, and a reset-free array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (capture) begin
            data_buf_q <= c_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            overrun_q <= 1'b0;
        end else begin
            if (done_in && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE:    if (done_in)             state_q <= STREAM;
                STREAM:  if (handshake && at_end) state_q <= AFTER_LAST;
                CKSUM:   if (handshake)           state_q <= IDLE;
                default:                          state_q <= IDLE;
            endcase
        end
    end

`ifdef STRASSEN_STREAM_CKSUM_EN
    logic signed [DW-1:0] cksum_q;

    always_ff @(posedge clk) begin
        if (!rst_n || capture) begin
            cksum_q <= '0;
        end else if (stream_hs) begin
            cksum_q <= cksum_q + out_data;
        end
    end
`endif

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        case (state_q)
            STREAM: begin
                out_data = data_buf_q[row][col];
`ifndef STRASSEN_STREAM_CKSUM_EN
                out_last = at_end;
`endif
            end
`ifdef STRASSEN_STREAM_CKSUM_EN
            CKSUM: begin
                out_data = cksum_q;
                out_last = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_row   = row;
    assign out_col   = col;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_strassen_result_streamer.sv
// Randomized bench for strassen_result_streamer against a row-major frame model.
// Honors STRASSEN_STREAM_CKSUM_EN when the design is built with it.
module tb_strassen_result_streamer;
    import strassen_stream_pkg::*;

    localparam int N  = N_DEFAULT;
    localparam int IW = $clog2(N);
`ifdef STRASSEN_STREAM_CKSUM_EN
    localparam int NB = N * N + 1;
`else
    localparam int NB = N * N;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          done_in = 1'b0;
    logic          out_ready = 1'b0;
    matrix_t       c_in;
    logic          busy, out_valid, out_last, overrun;
    elem_t         out_data;
    logic [IW-1:0] out_row, out_col;

    int pass_cnt = 0;
    int total_cnt = 0;

    elem_t         obs_data[$], exp_data[$];
    logic [IW-1:0] obs_row[$], exp_row[$], obs_col[$], exp_col[$];
    logic          obs_last[$], exp_last[$];
    int            stall_err, drain_cycles;
    bit            drain_timeout;

    always #5 clk = ~clk;

    strassen_result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done_in   (done_in),
        .c_in      (c_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: one beat per element in row-major order, then optional wrapping sum.
    function automatic void build_expected(input matrix_t m);
        elem_t sum = '0;
        exp_data.delete(); exp_row.delete(); exp_col.delete(); exp_last.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp_data.push_back(m[i][j]);
                exp_row.push_back(IW'(i));
                exp_col.push_back(IW'(j));
                exp_last.push_back(1'b0);
                sum = sum + m[i][j];
            end
        end
`ifdef STRASSEN_STREAM_CKSUM_EN
        exp_data.push_back(sum);
        exp_row.push_back(IW'(N - 1));
        exp_col.push_back(IW'(N - 1));
        exp_last.push_back(1'b1);
`else
        exp_last[exp_last.size() - 1] = 1'b1;
`endif
    endfunction

    function automatic int frame_errors(output int first_bad);
        int e = 0;
        int n = (obs_data.size() > exp_data.size()) ? obs_data.size() : exp_data.size();
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (k >= obs_data.size() || k >= exp_data.size() ||
                obs_data[k] !== exp_data[k] || obs_row[k] !== exp_row[k] ||
                obs_col[k] !== exp_col[k] || obs_last[k] !== exp_last[k]) begin
                e++;
                if (first_bad < 0) first_bad = k;
            end
        end
        return e;
    endfunction

    function automatic matrix_t random_matrix();
        matrix_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = elem_t'($urandom_range(0, 65535));
        return m;
    endfunction

    function automatic matrix_t ramp_matrix();
        matrix_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = elem_t'(i * 16 + j);
        return m;
    endfunction

    task automatic start_frame(input matrix_t m);
        c_in    = m;
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
    endtask

    // Collects accepted beats until out_valid falls; optionally stops early or pulses done_in.
    task automatic drain(input bit rand_ready, input int stop_at, input int pulse_at,
                         input matrix_t alt);
        elem_t         pd = '0;
        logic [IW-1:0] pr = '0, pc = '0;
        logic          pl = 1'b0;
        bit            stalled = 1'b0, pulsed = 1'b0;
        int            n = 0;
        obs_data.delete(); obs_row.delete(); obs_col.delete(); obs_last.delete();
        stall_err = 0; drain_cycles = 0; drain_timeout = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!out_valid) begin
                if (stalled) stall_err++;
                done_in = 1'b0; out_ready = 1'b0;
                return;
            end
            if (stalled && (out_data !== pd || out_row !== pr || out_col !== pc || out_last !== pl))
                stall_err++;
            if (n == stop_at) begin
                done_in = 1'b0; out_ready = 1'b0;
                return;
            end
            if (n == pulse_at && !pulsed) begin
                c_in = alt; done_in = 1'b1; pulsed = 1'b1;
            end else begin
                done_in = 1'b0;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
                obs_data.push_back(out_data); obs_row.push_back(out_row);
                obs_col.push_back(out_col);   obs_last.push_back(out_last);
                n++;
            end
            stalled = !out_ready;
            pd = out_data; pr = out_row; pc = out_col; pl = out_last;
            @(negedge clk);
            drain_cycles++;
        end
        drain_timeout = 1'b1; done_in = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; done_in = 1'b0; out_ready = 1'b0;
        c_in = ramp_matrix();
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({out_valid, busy, out_last, overrun} !== 4'b0000)
            $display("FAIL reset_flags: valid/busy/last/overrun=%b required 0000",
                     {out_valid, busy, out_last, overrun});
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 16'sd0) $display("FAIL reset_data: got %0d required 0", out_data);
        else pass_cnt++;
        total_cnt++;
        if ({out_row, out_col} !== '0)
            $display("FAIL reset_index: row=%0d col=%0d required 0,0", out_row, out_col);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_full_rate();
        matrix_t m = ramp_matrix();
        int e, fb;
        elem_t last_exp;
        build_expected(m);
        start_frame(m);
        total_cnt++;
        if ({busy, out_valid} !== 2'b11 || out_row !== '0 || out_col !== '0)
            $display("FAIL ramp_start: busy/valid=%b row=%0d col=%0d required 11,0,0",
                     {busy, out_valid}, out_row, out_col);
        else pass_cnt++;
        drain(1'b0, -1, -1, m);
        total_cnt++;
        if (drain_timeout) $display("FAIL ramp_timeout: frame did not end, required end");
        else pass_cnt++;
        total_cnt++;
        if (drain_cycles !== NB) $display("FAIL ramp_busy_fall: busy for %0d cycles required %0d", drain_cycles, NB);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL ramp_busy_low: busy=%b required 0", busy);
        else pass_cnt++;
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0) $display("FAIL ramp_frame: %0d bad beats (first %0d) required 0", e, fb);
        else pass_cnt++;
`ifdef STRASSEN_STREAM_CKSUM_EN
        last_exp = 16'h7F80;
`else
        last_exp = 16'sd255;
`endif
        total_cnt++;
        if (obs_data.size() == 0 || obs_data[$] !== last_exp || obs_last[$] !== 1'b1)
            $display("FAIL ramp_last_beat: data=%0h last=%b required %0h,1",
                     obs_data.size() ? obs_data[$] : 16'hxxxx,
                     obs_last.size() ? obs_last[$] : 1'bx, last_exp);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        matrix_t m = ramp_matrix();
        int e, fb;
        build_expected(m);
        start_frame(m);
        drain(1'b1, -1, -1, m);
        total_cnt++;
        if (drain_timeout || stall_err !== 0)
            $display("FAIL bp_stable: timeout=%b stall violations=%0d required 0,0", drain_timeout, stall_err);
        else pass_cnt++;
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0) $display("FAIL bp_frame: %0d bad beats (first %0d) required 0", e, fb);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        matrix_t m;
        int e, fb;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = elem_t'(-(i + j));
        build_expected(m);
        start_frame(m);
        drain(1'b1, -1, -1, m);
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0 || stall_err !== 0)
            $display("FAIL neg_frame: %0d bad beats (first %0d), stalls %0d required 0,0", e, fb, stall_err);
        else pass_cnt++;
        total_cnt++;
        if (obs_data.size() < N * N || obs_data[N * N - 1] !== 16'hFFE2)
            $display("FAIL neg_corner: got %0h required ffe2",
                     obs_data.size() >= N * N ? obs_data[N * N - 1] : 16'hxxxx);
        else pass_cnt++;
    endtask

    task automatic test_random_matrix();
        for (int r = 0; r < 2; r++) begin
            matrix_t m = random_matrix();
            int e, fb;
            build_expected(m);
            start_frame(m);
            drain(1'b1, -1, -1, m);
            e = frame_errors(fb);
            total_cnt++;
            if (e !== 0 || stall_err !== 0 || drain_timeout)
                $display("FAIL rand_frame%0d: %0d bad beats (first %0d), stalls %0d required 0,0",
                         r, e, fb, stall_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        matrix_t a = random_matrix();
        matrix_t b = random_matrix();
        int e, fb;
        bit valid_seen = 1'b0;
        build_expected(a);
        start_frame(a);
        drain(1'b1, -1, 100, b);
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0) $display("FAIL ovr_original_frame: %0d bad beats (first %0d) required 0", e, fb);
        else pass_cnt++;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) valid_seen = 1'b1;
        end
        total_cnt++;
        if (overrun !== 1'b1 || valid_seen)
            $display("FAIL ovr_sticky: overrun=%b stray valid=%b required 1,0", overrun, valid_seen);
        else pass_cnt++;
        build_expected(b);
        start_frame(b);
        drain(1'b0, -1, -1, b);
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0 || overrun !== 1'b1)
            $display("FAIL ovr_next_frame: %0d bad beats (first %0d) overrun=%b required 0,1", e, fb, overrun);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        matrix_t a = random_matrix();
        int e, fb;
        bit valid_seen = 1'b0;
        start_frame(a);
        drain(1'b1, 50, -1, a);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, busy, overrun} !== 3'b000)
            $display("FAIL rst_mid_flags: valid/busy/overrun=%b required 000", {out_valid, busy, overrun});
        else pass_cnt++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) valid_seen = 1'b1;
        end
        out_ready = 1'b0;
        total_cnt++;
        if (valid_seen) $display("FAIL rst_mid_quiet: valid after reset=%b required 0", valid_seen);
        else pass_cnt++;
        a = random_matrix();
        build_expected(a);
        start_frame(a);
        drain(1'b1, -1, -1, a);
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0) $display("FAIL rst_mid_restart: %0d bad beats (first %0d) required 0", e, fb);
        else pass_cnt++;
    endtask

    task automatic test_done_on_final_handshake();
        matrix_t a = random_matrix();
        matrix_t b = random_matrix();
        int e, fb;
        bit valid_seen = 1'b0;
        build_expected(a);
        start_frame(a);
        drain(1'b0, -1, NB - 1, b);
        e = frame_errors(fb);
        total_cnt++;
        if (e !== 0) $display("FAIL final_hs_frame: %0d bad beats (first %0d) required 0", e, fb);
        else pass_cnt++;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || busy) valid_seen = 1'b1;
        end
        total_cnt++;
        if (valid_seen || overrun !== 1'b1)
            $display("FAIL final_hs_ignored: restarted=%b overrun=%b required 0,1", valid_seen, overrun);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ramp_full_rate();
        test_backpressure();
        test_negative();
        test_random_matrix();
        test_overrun();
        test_reset_midstream();
        test_done_on_final_handshake();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
